// File: rtl/clock_enable_gen_if.sv
// Config port bundle for clock_enable_gen: one valid/ready transfer carries {chan, div}.
// cfg_phase is present only when CLKGEN_PHASE_EN is defined.
interface clock_enable_gen_if #(
   parameter int CHANNELS  = 4,
   parameter int DIV_WIDTH = 16
);
   localparam int CHAN_WIDTH = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

   logic                  cfg_valid;
   logic                  cfg_ready;
   logic [CHAN_WIDTH-1:0] cfg_chan;
   logic [DIV_WIDTH-1:0]  cfg_div;
`ifdef CLKGEN_PHASE_EN
   logic [DIV_WIDTH-1:0]  cfg_phase;

   modport master (
      output cfg_valid,
      output cfg_chan,
      output cfg_div,
      output cfg_phase,
      input  cfg_ready
   );

   modport slave (
      input  cfg_valid,
      input  cfg_chan,
      input  cfg_div,
      input  cfg_phase,
      output cfg_ready
   );
`else
   modport master (
      output cfg_valid,
      output cfg_chan,
      output cfg_div,
      input  cfg_ready
   );

   modport slave (
      input  cfg_valid,
      input  cfg_chan,
      input  cfg_div,
      output cfg_ready
   );
`endif
endinterface

// File: rtl/clock_enable_gen.sv
// Multi-channel clock-enable generator: per-channel tick pulse and 50% square wave,
// reprogrammable glitch-free through a single-slot config port. Optional CLKGEN_PHASE_EN adds phase load and sync_all.
module clock_enable_gen #(
   parameter int CHANNELS    = 4,
   parameter int DIV_WIDTH   = 16,
   parameter int DEFAULT_DIV = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                run,
`ifdef CLKGEN_PHASE_EN
   input  logic                sync_all,
`endif
   clock_enable_gen_if.slave   cfg,
   output logic [CHANNELS-1:0] tick,
   output logic [CHANNELS-1:0] slow_clk,
   output logic [CHANNELS-1:0] locked
);
   localparam int                   CHAN_WIDTH = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam logic [DIV_WIDTH-1:0] DIV_ONE    = DIV_WIDTH'(1);
   localparam logic [DIV_WIDTH-1:0] DIV_RESET  = DIV_WIDTH'(DEFAULT_DIV);

   typedef enum logic {
      SLOT_EMPTY,
      SLOT_FULL
   } slot_state_t;

   slot_state_t slot_state;
   slot_state_t slot_next;

   logic                  cfg_ready_c;
   logic                  pending;
   logic                  accept;
   logic                  chan_valid;
   logic                  commit_any;
   logic                  slot_done;
   logic [CHAN_WIDTH-1:0] pend_chan;
   logic [DIV_WIDTH-1:0]  pend_div;
   logic [DIV_WIDTH-1:0]  pend_load;

   logic [DIV_WIDTH-1:0]  div_q [CHANNELS];
   logic [DIV_WIDTH-1:0]  cnt_q [CHANNELS];
   logic [CHANNELS-1:0]   enabled;
   logic [CHANNELS-1:0]   wrap;
   logic [CHANNELS-1:0]   commit;
   logic [CHANNELS-1:0]   sync_hit;

`ifdef CLKGEN_PHASE_EN
   logic [DIV_WIDTH-1:0]  pend_phase;
   logic [DIV_WIDTH-1:0]  phase_q [CHANNELS];
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         slot_state <= SLOT_EMPTY;
      end else begin
         slot_state <= slot_next;
      end
   end

   always_comb begin
      slot_next = slot_state;
      unique case (slot_state)
         SLOT_EMPTY: if (cfg.cfg_valid) slot_next = SLOT_FULL;
         SLOT_FULL:  if (slot_done)     slot_next = SLOT_EMPTY;
         default:    slot_next = SLOT_EMPTY;
      endcase
   end

   always_comb begin
      pending     = 1'b0;
      cfg_ready_c = 1'b0;
      unique case (slot_state)
         SLOT_EMPTY: cfg_ready_c = !rst;
         SLOT_FULL:  pending     = 1'b1;
         default:    pending     = 1'b0;
      endcase
   end

   assign cfg.cfg_ready = cfg_ready_c;
   assign accept        = cfg.cfg_valid & cfg_ready_c;

   always_ff @(posedge clk) begin
      if (rst) begin
         pend_chan  <= '0;
         pend_div   <= '0;
`ifdef CLKGEN_PHASE_EN
         pend_phase <= '0;
`endif
      end else if (accept) begin
         pend_chan  <= cfg.cfg_chan;
         pend_div   <= cfg.cfg_div;
`ifdef CLKGEN_PHASE_EN
         pend_phase <= cfg.cfg_phase;
`endif
      end
   end

   // An out-of-range phase would never reach the wrap compare, so it falls back to zero.
`ifdef CLKGEN_PHASE_EN
   assign pend_load = (pend_phase >= pend_div) ? '0 : pend_phase;
`else
   assign pend_load = '0;
`endif

   always_comb begin
      enabled    = '0;
      wrap       = '0;
      commit     = '0;
      sync_hit   = '0;
      chan_valid = (32'(pend_chan) < CHANNELS);
      for (int i = 0; i < CHANNELS; i++) begin
         enabled[i]  = (div_q[i] != '0);
         wrap[i]     = enabled[i] && run && (cnt_q[i] == div_q[i] - DIV_ONE);
`ifdef CLKGEN_PHASE_EN
         sync_hit[i] = sync_all && enabled[i];
`endif
         commit[i]   = pending && chan_valid && (32'(pend_chan) == i) &&
                       !sync_hit[i] && (!enabled[i] || wrap[i]);
      end
      commit_any = |commit;
      slot_done  = commit_any || !chan_valid;
   end

   // A commit lands on the wrap edge so the outgoing period always completes in full.
   always_ff @(posedge clk) begin
      for (int i = 0; i < CHANNELS; i++) begin
         if (rst) begin
            div_q[i]    <= DIV_RESET;
            cnt_q[i]    <= '0;
            tick[i]     <= 1'b0;
            slow_clk[i] <= 1'b0;
            locked[i]   <= 1'b0;
`ifdef CLKGEN_PHASE_EN
            phase_q[i]  <= '0;
         end else if (sync_hit[i]) begin
            cnt_q[i]    <= phase_q[i];
            tick[i]     <= 1'b0;
            slow_clk[i] <= 1'b0;
`endif
         end else if (commit[i]) begin
            locked[i] <= 1'b0;
            if (pend_div == '0) begin
               div_q[i]    <= '0;
               cnt_q[i]    <= '0;
               tick[i]     <= 1'b0;
               slow_clk[i] <= 1'b0;
            end else begin
               div_q[i]    <= pend_div;
               cnt_q[i]    <= pend_load;
               tick[i]     <= wrap[i];
               slow_clk[i] <= slow_clk[i] ^ wrap[i];
`ifdef CLKGEN_PHASE_EN
               phase_q[i]  <= pend_load;
`endif
            end
         end else if (wrap[i]) begin
            cnt_q[i]    <= '0;
            tick[i]     <= 1'b1;
            slow_clk[i] <= ~slow_clk[i];
            locked[i]   <= 1'b1;
         end else if (enabled[i] && run) begin
            cnt_q[i] <= cnt_q[i] + DIV_ONE;
            tick[i]  <= 1'b0;
         end else begin
            tick[i] <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_clock_enable_gen.sv
// Scoreboard bench for clock_enable_gen: a step-count reference model queues expected outputs,
// a negedge monitor pops and compares them against the DUT every cycle.
module tb_clock_enable_gen;
   localparam int CH     = 5;
   localparam int DW     = 8;
   localparam int DEF    = 2;
   localparam int CW     = (CH > 1) ? $clog2(CH) : 1;
   localparam int CYCLES = 3000;
`ifdef CLKGEN_PHASE_EN
   localparam bit PHASE_EN = 1'b1;
`else
   localparam bit PHASE_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          run;
   logic [DW-1:0] phase_drv;
   logic          sync_drv;
   logic [CH-1:0] tick;
   logic [CH-1:0] slow_clk;
   logic [CH-1:0] locked;

   clock_enable_gen_if #(.CHANNELS(CH), .DIV_WIDTH(DW)) cfg_bus ();

`ifdef CLKGEN_PHASE_EN
   logic sync_all;
   assign sync_all          = sync_drv;
   assign cfg_bus.cfg_phase = phase_drv;
`endif

   clock_enable_gen #(.CHANNELS(CH), .DIV_WIDTH(DW), .DEFAULT_DIV(DEF)) dut (
      .clk      (clk),
      .rst      (rst),
      .run      (run),
`ifdef CLKGEN_PHASE_EN
      .sync_all (sync_all),
`endif
      .cfg      (cfg_bus),
      .tick     (tick),
      .slow_clk (slow_clk),
      .locked   (locked)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [CH-1:0] tick;
      logic [CH-1:0] slow;
      logic [CH-1:0] locked;
      logic          ready;
      int            cyc;
   } exp_t;

   exp_t exp_q[$];
   int   compared = 0;
   int   failed   = 0;
   int   cyc_cnt  = 0;
   bit   cur_run  = 1'b0;

   // Model: each channel is a running step count; ticks fall on multiples of its divisor.
   int m_div    [CH];
   int m_steps  [CH];
   int m_phase  [CH];
   bit m_slow0  [CH];
   bit m_locked [CH];
   bit m_tick   [CH];
   bit m_pend;
   int m_pchan;
   int m_pdiv;
   int m_pphase;
   bit m_accepted;

   function automatic bit expSlow(input int ch);
      if (m_div[ch] == 0) return 1'b0;
      return m_slow0[ch] ^ bit'((m_steps[ch] / m_div[ch]) % 2);
   endfunction

   function automatic void modelStep();
      bit ready_pre;
      bit clr;
      bit target;
      bit slow_now;
      int ld;
      ready_pre  = !m_pend && !rst;
      m_accepted = 1'b0;
      if (rst) begin
         for (int c = 0; c < CH; c++) begin
            m_div[c]    = DEF;
            m_steps[c]  = 0;
            m_phase[c]  = 0;
            m_slow0[c]  = 1'b0;
            m_locked[c] = 1'b0;
            m_tick[c]   = 1'b0;
         end
         m_pend = 1'b0;
         return;
      end
      clr = m_pend && (m_pchan >= CH);
      ld  = (PHASE_EN && (m_pphase < m_pdiv)) ? m_pphase : 0;
      for (int c = 0; c < CH; c++) begin
         target = m_pend && (m_pchan == c);
         if (m_div[c] != 0 && PHASE_EN && sync_drv) begin
            m_steps[c] = m_phase[c];
            m_slow0[c] = 1'b0;
            m_tick[c]  = 1'b0;
         end else if (m_div[c] == 0) begin
            m_tick[c] = 1'b0;
            if (target) begin
               m_div[c]    = m_pdiv;
               m_steps[c]  = ld;
               m_phase[c]  = ld;
               m_slow0[c]  = 1'b0;
               m_locked[c] = 1'b0;
               clr = 1'b1;
            end
         end else if (run) begin
            m_steps[c]++;
            m_tick[c] = (m_steps[c] % m_div[c] == 0);
            if (m_tick[c]) m_locked[c] = 1'b1;
            if (target && m_tick[c]) begin
               slow_now    = expSlow(c);
               m_locked[c] = 1'b0;
               if (m_pdiv == 0) begin
                  m_div[c]   = 0;
                  m_steps[c] = 0;
                  m_slow0[c] = 1'b0;
                  m_tick[c]  = 1'b0;
               end else begin
                  m_div[c]   = m_pdiv;
                  m_steps[c] = ld;
                  m_phase[c] = ld;
                  m_slow0[c] = slow_now;
               end
               clr = 1'b1;
            end
         end else begin
            m_tick[c] = 1'b0;
         end
      end
      if (clr) m_pend = 1'b0;
      if (ready_pre && cfg_bus.cfg_valid) begin
         m_pend     = 1'b1;
         m_pchan    = int'(cfg_bus.cfg_chan);
         m_pdiv     = int'(cfg_bus.cfg_div);
         m_pphase   = int'(phase_drv);
         m_accepted = 1'b1;
      end
   endfunction

   function automatic void pushExpected();
      exp_t e;
      for (int c = 0; c < CH; c++) begin
         e.tick[c]   = m_tick[c];
         e.slow[c]   = expSlow(c);
         e.locked[c] = m_locked[c];
      end
      e.ready = !m_pend && !rst;
      e.cyc   = cyc_cnt;
      exp_q.push_back(e);
   endfunction

   task automatic checkOutput(input string name, input int cyc,
                              input logic [CH-1:0] act, input logic [CH-1:0] req);
      compared++;
      if (act !== req) begin
         failed++;
         $display("[TB] FAIL %s cycle=%0d actual=%b required=%b", name, cyc, act, req);
      end
   endtask

   task automatic applyStimulus(input bit r, input bit rn, input bit v,
                                input logic [CW-1:0] ch, input logic [DW-1:0] d,
                                input logic [DW-1:0] ph, input bit sy);
      rst               = r;
      run               = rn;
      cfg_bus.cfg_valid = v;
      cfg_bus.cfg_chan  = ch;
      cfg_bus.cfg_div   = d;
      phase_drv         = ph;
      sync_drv          = sy;
      pushExpected();
      @(posedge clk);
      modelStep();
      cyc_cnt++;
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) applyStimulus(1'b0, cur_run, 1'b0, '0, '0, '0, 1'b0);
   endtask

   task automatic writeCfg(input logic [CW-1:0] ch, input logic [DW-1:0] d, input logic [DW-1:0] ph);
      int n;
      n = 0;
      do begin
         applyStimulus(1'b0, cur_run, 1'b1, ch, d, ph, 1'b0);
         n++;
      end while (!m_accepted && n < 100);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checkOutput("tick", e.cyc, tick, e.tick);
         checkOutput("slow_clk", e.cyc, slow_clk, e.slow);
         checkOutput("locked", e.cyc, locked, e.locked);
         checkOutput("cfg_ready", e.cyc, CH'(cfg_bus.cfg_ready), CH'(e.ready));
      end
   end

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      bit            r;
      bit            rn;
      bit            v;
      bit            sy;
      int            pick;
      logic [CW-1:0] ch;
      logic [DW-1:0] d;
      logic [DW-1:0] ph;

      rst               = 1'b1;
      run               = 1'b0;
      cfg_bus.cfg_valid = 1'b0;
      cfg_bus.cfg_chan  = '0;
      cfg_bus.cfg_div   = '0;
      phase_drv         = '0;
      sync_drv          = 1'b0;
      @(posedge clk);
      modelStep();
      #1;
      applyStimulus(1'b1, 1'b0, 1'b0, '0, '0, '0, 1'b0);

      $display("[TB] directed sequence");
      cur_run = 1'b1;
      idle(12);
      writeCfg(CW'(0), DW'(5), '0);
      idle(25);
      writeCfg(CW'(1), DW'(0), '0);
      idle(6);
      writeCfg(CW'(1), DW'(3), '0);
      idle(10);
      writeCfg(CW'(2), DW'(4), '0);
      idle(9);
      cur_run = 1'b0;
      idle(7);
      cur_run = 1'b1;
      idle(10);
      writeCfg(CW'(7), DW'(6), '0);
      idle(3);
      writeCfg(CW'(3), DW'(9), '0);
      applyStimulus(1'b1, 1'b1, 1'b0, '0, '0, '0, 1'b0);
      idle(8);
      writeCfg(CW'(0), DW'(4), DW'(0));
      idle(6);
      writeCfg(CW'(1), DW'(4), DW'(2));
      idle(6);
      applyStimulus(1'b0, 1'b1, 1'b0, '0, '0, '0, 1'b1);
      idle(12);
      writeCfg(CW'(2), DW'(4), DW'(9));
      idle(12);

      $display("[TB] randomized sequence");
      for (int k = 0; k < CYCLES; k++) begin
         r    = ($urandom_range(0, 299) == 0);
         rn   = ($urandom_range(0, 9) != 0);
         v    = ($urandom_range(0, 3) == 0);
         ch   = CW'($urandom_range(0, 7));
         pick = $urandom_range(0, 9);
         d    = (pick < 6) ? DW'(pick) : DW'($urandom_range(0, 12));
         ph   = DW'($urandom_range(0, 9));
         sy   = ($urandom_range(0, 49) == 0);
         applyStimulus(r, rn, v, ch, d, ph, sy);
      end

      cur_run = 1'b1;
      idle(1);
      for (int k = 0; k < 4 && exp_q.size() > 0; k++) @(negedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
      $finish;
   end
endmodule
